// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding and the request address check.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Misaligned or past the last word: no aliasing of high addresses.
    function automatic logic addr_err(
        input logic [31:0] addr,
        input int unsigned depth
    );
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WORD_W word store: one synchronous write port,
// one asynchronous read port, cleared by the async reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store target: one outstanding request,
// programmable response latency, registered handshake outputs.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              ready_q;
    logic              valid_q;
    logic              err_q;
    logic [WORD_W-1:0] rdata_q;

    logic              acc;
    logic              err;
    logic              we;
    logic [AW-1:0]     idx;
    logic [WORD_W-1:0] arr_rdata;

    assign acc = req_valid && ready_q;
    assign err = addr_err(req_addr, DEPTH);
    assign idx = req_addr[AW+1:2];
    assign we  = acc && req_write && !err;

    dmem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (we),
        .waddr_i(idx),
        .wdata_i(req_wdata),
        .raddr_i(idx),
        .rdata_o(arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (acc) begin
                        err_q   <= err;
                        rdata_q <= (!err && !req_write) ? arr_rdata : '0;
                        cnt_q   <= 4'(LATENCY - 1);
                        ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                        valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        err_q   <= 1'b0;
                        rdata_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed checks of dmem_responder at LATENCY 2, 1, 15
// against a word-array reference model.
module tb_dmem_responder;

    localparam int N = 3;
    localparam int D = 64;
    localparam int LAT [N] = '{2, 1, 15};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        req_valid  [N];
    logic        req_ready  [N];
    logic        req_write  [N];
    logic [31:0] req_addr   [N];
    logic [31:0] req_wdata  [N];
    logic        resp_valid [N];
    logic        resp_ready [N];
    logic [31:0] resp_rdata [N];
    logic        resp_err   [N];

    logic [31:0] mem_m [N][D];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .DEPTH  (D),
            .LATENCY(LAT[g])
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g])
        );
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < D; j++)
                mem_m[i][j] = 32'h0;
    endfunction

    function automatic void model(input int d, input logic w,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic e, output logic [31:0] rd);
        int unsigned word;
        word = a / 4;
        e = (a % 4 != 0) || (word >= D);
        rd = 32'h0;
        if (!e) begin
            if (w) mem_m[d][word] = wd;
            else   rd = mem_m[d][word];
        end
    endfunction

    function automatic logic [31:0] rand_addr(input int span);
        int unsigned k;
        k = $urandom_range(0, 5);
        if (k == 0) return 32'($urandom_range(0, 300)) | 32'($urandom_range(1, 3));
        if (k == 1) return 32'($urandom_range(D, 2000)) << 2;
        if (k == 2) return {$urandom} & 32'hFFFF_FFFC | 32'h8000_0000;
        return 32'($urandom_range(0, span - 1)) << 2;
    endfunction

    task automatic txn(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input int hold, input string tag);
        logic e;
        logic [31:0] rd;
        logic [31:0] held;
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_write[d] = w;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/accept"}, 32'(req_ready[d]), 32'd1);
        model(d, w, a, wd, e, rd);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_write[d] = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        n = 1;
        while (!resp_valid[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/latency"}, 32'(n), 32'(LAT[d]));
        check({tag, "/err"}, 32'(resp_err[d]), 32'(e));
        check({tag, "/rdata"}, resp_rdata[d], rd);
        check({tag, "/req_ready_busy"}, 32'(req_ready[d]), 32'd0);
        held = resp_rdata[d];
        for (int i = 0; i < hold; i++) begin
            req_valid[d] = 1'b1;
            @(negedge clk);
            check({tag, "/bp_valid"}, 32'(resp_valid[d]), 32'd1);
            check({tag, "/bp_rdata"}, resp_rdata[d], held);
            check({tag, "/bp_ready"}, 32'(req_ready[d]), 32'd0);
        end
        req_valid[d] = 1'b0;
        resp_ready[d] = 1'b1;
        @(negedge clk);
        resp_ready[d] = 1'b0;
        check({tag, "/done_valid"}, 32'(resp_valid[d]), 32'd0);
        check({tag, "/done_ready"}, 32'(req_ready[d]), 32'd1);
    endtask

    task automatic stream(input int d, input int cycles);
        logic e_q [$];
        logic [31:0] rd_q [$];
        int t_q [$];
        int last;
        int nresp;
        logic e;
        logic [31:0] rd;
        last = -1;
        nresp = 0;
        @(negedge clk);
        resp_ready[d] = 1'b1;
        for (int c = 0; c < cycles + 40; c++) begin
            req_valid[d] = (c < cycles);
            req_write[d] = 1'($urandom);
            req_addr[d]  = rand_addr(6);
            req_wdata[d] = $urandom;
            if (resp_valid[d]) begin
                check($sformatf("s%0d/resp_expected", d),
                      32'(t_q.size() > 0), 32'd1);
                if (t_q.size() > 0) begin
                    check($sformatf("s%0d/resp_time", d),
                          32'(c - t_q.pop_front()), 32'(LAT[d]));
                    check($sformatf("s%0d/err", d),
                          32'(resp_err[d]), 32'(e_q.pop_front()));
                    check($sformatf("s%0d/rdata", d),
                          resp_rdata[d], rd_q.pop_front());
                    nresp++;
                end
            end
            if (req_ready[d] && req_valid[d]) begin
                if (last >= 0)
                    check($sformatf("s%0d/spacing", d),
                          32'(c - last), 32'(LAT[d] + 1));
                last = c;
                model(d, req_write[d], req_addr[d], req_wdata[d], e, rd);
                e_q.push_back(e);
                rd_q.push_back(rd);
                t_q.push_back(c);
            end
            @(negedge clk);
        end
        resp_ready[d] = 1'b0;
        req_valid[d] = 1'b0;
        check($sformatf("s%0d/drained", d), 32'(t_q.size()), 32'd0);
        check($sformatf("s%0d/enough", d), 32'(nresp >= 5), 32'd1);
    endtask

    task automatic reset_mid(input logic w, input logic [31:0] a,
                             input logic [31:0] wd, input string tag);
        int n;
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = w;
        req_addr[0]  = a;
        req_wdata[0] = wd;
        n = 0;
        while (!req_ready[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, "/rst_ready"}, 32'(req_ready[0]), 32'd1);
        check({tag, "/rst_valid"}, 32'(resp_valid[0]), 32'd0);
        check({tag, "/rst_rdata"}, resp_rdata[0], 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check({tag, "/no_resp"}, 32'(resp_valid[0]), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < N; i++) begin
            req_valid[i]  = 1'b0;
            req_write[i]  = 1'b0;
            req_addr[i]   = 32'h0;
            req_wdata[i]  = 32'h0;
            resp_ready[i] = 1'b0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("reset%0d/req_ready", i), 32'(req_ready[i]), 32'd1);
            check($sformatf("reset%0d/resp_valid", i), 32'(resp_valid[i]), 32'd0);
            check($sformatf("reset%0d/rdata", i), resp_rdata[i], 32'h0);
            check($sformatf("reset%0d/err", i), 32'(resp_err[i]), 32'd0);
        end

        txn(0, 1'b0, 32'h8, 32'h0, 0, "ld08");
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, "st10");
        txn(0, 1'b0, 32'h10, 32'h0, 5, "ld10_bp");
        txn(0, 1'b1, 32'h0, 32'h1234_5678, 0, "st00");
        txn(0, 1'b0, 32'h12, 32'h0, 0, "ld12_mis");
        txn(0, 1'b1, 32'h100, 32'hFFFF_FFFF, 0, "st100_oor");
        txn(0, 1'b0, 32'h0, 32'h0, 0, "ld00");
        txn(0, 1'b1, 32'hFC, 32'hA5A5_5A5A, 1, "st_last");
        txn(0, 1'b0, 32'hFC, 32'h0, 2, "ld_last");
        txn(0, 1'b0, 32'h4000_0000, 32'h0, 0, "ld_high");

        for (int i = 0; i < 24; i++) begin
            a = rand_addr(8);
            txn(0, 1'($urandom), a, $urandom, $urandom_range(0, 2),
                $sformatf("rnd%0d", i));
        end

        stream(1, 120);
        stream(2, 260);

        txn(0, 1'b1, 32'h20, 32'hCAFE_F00D, 0, "st20");
        reset_mid(1'b0, 32'h20, 32'h0, "rst_ld");
        txn(0, 1'b0, 32'h20, 32'h0, 0, "ld20_cleared");
        reset_mid(1'b1, 32'h24, 32'h0BAD_CAFE, "rst_st");
        txn(0, 1'b0, 32'h24, 32'h0, 0, "ld24_cleared");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the target end of the processor's load/store port. It accepts one word request at a time over a valid/ready handshake and performs it against an internal word array. After a programmable latency it returns read data, or a write acknowledge, over a second valid/ready handshake. It replaces the combinational data store when the core is moved to a stalling memory interface.

## Interface

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, ≥2.
- LATENCY, 2, cycles from request acceptance edge to first resp_valid high; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  initiator accepts the response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  request was misaligned or out of range.

## Operation

- States: IDLE, WAIT, RESP.
  - IDLE: req_ready=1, resp_valid=0.
  - WAIT: req_ready=0, resp_valid=0. The latency counter is running.
  - RESP: req_ready=0, resp_valid=1.
- Acceptance occurs at a rising edge where req_valid && req_ready. At that edge:
  - req_write, req_addr and req_wdata are latched.
  - Error check: err = (addr[1:0]≠0) || (addr[31:2] ≥ DEPTH).
  - A store with !err writes word addr[log2(DEPTH)+1:2]. The write commits on this edge.
  - A load with !err captures the array word into the rdata register.
  - The counter loads LATENCY-1.
  - Next state is RESP if LATENCY=1, otherwise WAIT.
- WAIT: the counter decrements each cycle. The state moves to RESP on the edge where the counter equals 1.
- RESP:
  - Outputs stay stable until resp_valid && resp_ready at an edge, then the state returns to IDLE.
  - resp_ready is ignored outside RESP.
- Error requests follow the same timing with resp_err=1 and resp_rdata=0. The array is never modified by an error request.
- Inputs other than req_valid are don't-care unless acceptance occurs. req_valid may be held high across responses; each accepted request is counted once.
- There is no request pipelining: at most one request is outstanding.

## Timing

- Reset (asynchronous assert, synchronous-safe deassert):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
  - All array words are 0.
- Latency: request accepted at edge T gives resp_valid=1 after edge T+LATENCY-1, i.e. in the cycle following edge T+LATENCY-1.
- Minimum request-to-request spacing: LATENCY+1 cycles when resp_ready is tied high.
- Read-after-write: a load accepted after a store's response has completed returns the new data. No bypass is needed.
- Reset mid-transaction (WAIT or RESP): the response is dropped and the state goes to IDLE.
  - A store that was accepted before reset is overwritten by the array clear.
- Address wrap: none. Any word index ≥ DEPTH is an error, never aliased.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure

- Package dmem_pkg:
  - state enum {IDLE, WAIT, RESP}
  - WORD_W=32
  - error-check helper function (alignment and range given DEPTH)
- Sub-module dmem_array: DEPTH×32 storage with one synchronous write port, one read port and asynchronous clear. The FSM, counter and handshake logic live in the top.

## Test plan

- Reset then idle: after rst_n rises, req_ready=1, resp_valid=0, resp_rdata=0; a load from 0x8 returns 0x00000000, err=0.
- Store/load, LATENCY=2: store 0xDEADBEEF to 0x10, accepted at edge T; resp_valid rises at T+2 with err=0 and rdata=0. Then load 0x10 returns 0xDEADBEEF two edges after acceptance.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP. resp_valid and resp_rdata stay stable, req_ready=0, and a second req_valid is not accepted until the response completes.
- Errors: load 0x12 gives err=1, rdata=0. Store 0x00000100 with DEPTH=64 gives err=1, and a later load of word 0 is still unchanged.
- Latency sweep: LATENCY=1 and LATENCY=15, with req_valid and resp_ready tied high. Response cycle count and request spacing (LATENCY+1) must match exactly.
- Reset mid-WAIT: assert rst_n=0 one cycle after accepting a load. resp_valid never rises, and the state is IDLE with req_ready=1 immediately on reset assertion.
